// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multicycle ALU with valid/ready handshakes, iterative shifts and shift-add multiply
module alu_mc #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  read1,
   input  logic [W-1:0]  read0,
   input  logic [3:0]    alu_op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  result,
   output logic          branch_result,
   output logic          zero_flag,
   output logic          carry_flag
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_SLB = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SHL = 4'd3;
   localparam logic [3:0] OP_SHR = 4'd4;
   localparam logic [3:0] OP_BNZ = 4'd5;
   localparam logic [3:0] OP_SLT = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
   localparam logic [3:0] OP_AND = 4'd8;
   localparam logic [3:0] OP_OR  = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_SRA = 4'd11;

   logic [1:0]     r_state;
   logic [3:0]     r_op;
   logic [W-1:0]   r_a;
   logic [2*W-1:0] r_acc;
   logic [CW-1:0]  r_cnt;
   logic           r_sc;
   logic [W-1:0]   r_result;
   logic           r_branch;
   logic           r_zero;
   logic           r_carry;

   logic [W:0]     w_add;
   logic [W:0]     w_sub;
   logic [CW-1:0]  w_cnt;
   logic           w_is_shift;
   logic [W-1:0]   w_res;
   logic           w_br;
   logic           w_cy;
   logic [W:0]     w_step;
   logic [2*W-1:0] w_acc_next;
   logic [W-1:0]   w_sh_next;
   logic           w_sh_out;
   logic           w_last;

   assign w_add      = {1'b0, read1} + {1'b0, read0};
   assign w_sub      = {1'b0, read1} - {1'b0, read0};
   assign w_cnt      = (read0 >= W'(W)) ? CW'(W) : read0[CW-1:0];
   assign w_is_shift = (alu_op == OP_SHL) || (alu_op == OP_SHR) || (alu_op == OP_SRA);
   assign w_last     = (r_cnt == CW'(1));

   always_comb begin
      w_res = '0;
      w_br  = 1'b0;
      w_cy  = 1'b0;
      case (alu_op)
         OP_SLB: w_res = {read1[W-1:W/2], read0[W/2-1:0]};
         OP_ADD: begin
            w_res = w_add[W-1:0];
            w_cy  = w_add[W];
         end
         OP_SUB: begin
            w_res = w_sub[W-1:0];
            w_cy  = w_sub[W];
         end
         // Only reached with a zero shift count; nonzero counts iterate in BUSY.
         OP_SHL, OP_SHR, OP_SRA: w_res = read1;
         OP_BNZ: w_br  = |read1;
         OP_SLT: w_res = {{(W-1){1'b0}}, (read1 < read0)};
         OP_XOR: w_res = read1 ^ read0;
         OP_AND: w_res = read1 & read0;
         OP_OR:  w_res = read1 | read0;
         default: ;
      endcase
   end

   // Shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
   assign w_step     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
   assign w_acc_next = {w_step, r_acc[W-1:1]};

   always_comb begin
      w_sh_next = r_a;
      w_sh_out  = 1'b0;
      case (r_op)
         OP_SHL: begin
            w_sh_next = {r_a[W-2:0], 1'b0};
            w_sh_out  = r_a[W-1];
         end
         OP_SHR:  w_sh_next = {1'b0, r_a[W-1:1]};
         OP_SRA:  w_sh_next = {r_a[W-1], r_a[W-1:1]};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_a      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sc     <= 1'b0;
         r_result <= '0;
         r_branch <= 1'b0;
         r_zero   <= 1'b0;
         r_carry  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op  <= alu_op;
                  r_a   <= read1;
                  r_acc <= {{W{1'b0}}, read0};
                  r_sc  <= 1'b0;
                  if (alu_op == OP_MUL) begin
                     r_cnt   <= CW'(W);
                     r_state <= S_BUSY;
                  end else if (w_is_shift && (w_cnt != '0)) begin
                     r_cnt   <= w_cnt;
                     r_state <= S_BUSY;
                  end else begin
                     r_result <= w_res;
                     r_branch <= w_br;
                     r_zero   <= (w_res == '0);
                     r_carry  <= w_cy;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_op == OP_MUL) begin
                  r_acc <= w_acc_next;
                  if (w_last) begin
                     r_result <= w_acc_next[W-1:0];
                     r_branch <= 1'b0;
                     r_zero   <= (w_acc_next[W-1:0] == '0);
                     r_carry  <= |w_acc_next[2*W-1:W];
                     r_state  <= S_DONE;
                  end
               end else begin
                  r_a  <= w_sh_next;
                  r_sc <= r_sc | w_sh_out;
                  if (w_last) begin
                     r_result <= w_sh_next;
                     r_branch <= 1'b0;
                     r_zero   <= (w_sh_next == '0);
                     r_carry  <= r_sc | w_sh_out;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready      = (r_state == S_IDLE);
   assign out_valid     = (r_state == S_DONE);
   assign result        = r_result;
   assign branch_result = r_branch;
   assign zero_flag     = r_zero;
   assign carry_flag    = r_carry;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc with directed vectors
module tb_alu_mc;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] read1;
   logic [W-1:0] read0;
   logic [3:0]   alu_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         branch_result;
   logic         zero_flag;
   logic         carry_flag;

   typedef struct packed {
      logic [W-1:0] res;
      logic         br;
      logic         z;
      logic         c;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_mc #(.W(W)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .read1         (read1),
      .read0         (read0),
      .alu_op        (alu_op),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .branch_result (branch_result),
      .zero_flag     (zero_flag),
      .carry_flag    (carry_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every completed output transfer is matched against the queue head.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got result %0h with no expected entry", result);
         end else begin
            e = q.pop_front();
            chk("result", {24'b0, result}, {24'b0, e.res});
            chk("branch", {31'b0, branch_result}, {31'b0, e.br});
            chk("zero", {31'b0, zero_flag}, {31'b0, e.z});
            chk("carry", {31'b0, carry_flag}, {31'b0, e.c});
         end
      end
   end

   task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = 1'b1;
      alu_op   = op;
      read1    = a;
      read0    = b;
   endtask

   task automatic accept(input exp_t e, input bit push);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready 0 expected 1");
      end
      @(posedge clk);
      if (push) q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name, input int lat_exp);
      int lat;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk(name, lat, lat_exp);
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res, input logic br,
                         input logic z, input logic c, input int lat);
      exp_t e;
      e = '{res: res, br: br, z: z, c: c};
      drive(op, a, b);
      accept(e, 1'b1);
      wait_out(name, lat);
   endtask

   initial begin
      bit seen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      read1     = '0;
      read0     = '0;
      alu_op    = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_result", {24'b0, result}, 0);
      chk("rst_branch", {31'b0, branch_result}, 0);
      chk("rst_zero", {31'b0, zero_flag}, 0);
      chk("rst_carry", {31'b0, carry_flag}, 0);

      run_op("lat_add", 4'd1, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, 1'b1, 1);
      @(negedge clk);
      chk("add_in_ready_plus2", {31'b0, in_ready}, 1);
      run_op("lat_add2", 4'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 1);
      run_op("lat_sub", 4'd2, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1);
      run_op("lat_sub_borrow", 4'd2, 8'h03, 8'h07, 8'hFC, 1'b0, 1'b0, 1'b1, 1);
      run_op("lat_slt", 4'd6, 8'h03, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1);
      run_op("lat_slt0", 4'd6, 8'h07, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 1);
      run_op("lat_xor", 4'd7, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
      run_op("lat_and", 4'd8, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1);
      run_op("lat_or", 4'd9, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1);
      run_op("lat_shl", 4'd3, 8'h81, 8'd3, 8'h08, 1'b0, 1'b0, 1'b1, 4);
      run_op("lat_shr", 4'd4, 8'hF0, 8'd4, 8'h0F, 1'b0, 1'b0, 1'b0, 5);
      run_op("lat_sra_sat", 4'd11, 8'h80, 8'd9, 8'hFF, 1'b0, 1'b0, 1'b0, 9);
      run_op("lat_sra", 4'd11, 8'h40, 8'd2, 8'h10, 1'b0, 1'b0, 1'b0, 3);
      run_op("lat_shl0", 4'd3, 8'h5A, 8'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
      run_op("lat_shl_sat", 4'd3, 8'hFF, 8'h20, 8'h00, 1'b0, 1'b1, 1'b1, 9);
      run_op("lat_mul", 4'd10, 8'h10, 8'h11, 8'h10, 1'b0, 1'b0, 1'b1, 9);
      run_op("lat_mul2", 4'd10, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b0, 9);
      run_op("lat_bnz1", 4'd5, 8'h05, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1);
      run_op("lat_nop", 4'd13, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1);

      // Backpressure: hold a BNZ result while a new op waits at the input.
      @(negedge clk);
      out_ready = 1'b0;
      run_op("lat_bnz0", 4'd5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1);
      drive(4'd1, 8'h01, 8'h02);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {27'b0, out_valid, in_ready, branch_result, zero_flag, (result == 8'h00)},
             {27'b0, 5'b10011});
         @(negedge clk);
      end
      out_ready = 1'b1;
      accept('{res: 8'h03, br: 1'b0, z: 1'b0, c: 1'b0}, 1'b1);
      wait_out("lat_bp_add", 1);

      // Reset lands on the 4th BUSY cycle of a MUL.
      @(negedge clk);
      drive(4'd10, 8'h03, 8'h05);
      accept('{res: 8'h0F, br: 1'b0, z: 1'b0, c: 1'b0}, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_in_ready", {31'b0, in_ready}, 1);
      chk("abort_out_valid", {31'b0, out_valid}, 0);
      chk("abort_result", {24'b0, result}, 0);
      chk("abort_flags", {29'b0, branch_result, zero_flag, carry_flag}, 0);
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      chk("abort_no_output", {31'b0, seen}, 0);
      run_op("lat_slb", 4'd0, 8'hAB, 8'hCD, 8'hAD, 1'b0, 1'b0, 1'b0, 1);

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multicycle successor to the core's 8-bit combinational ALU.
- Registered operands and valid/ready handshakes on both sides.
- Adds iterative shifts, an iterative unsigned multiply, arithmetic shift right, and zero/carry flags.
- Sits between the register-file read stage and writeback. Pipeline control stalls on `in_ready` / `out_valid`.

Parameters:
- W, 8, datapath width in bits. Must be even and ≥4.
- CW, $clog2(W+1), width of the internal iteration counter.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  block can accept an operation
- read1  input  W  first operand
- read0  input  W  second operand, or shift amount
- alu_op  input  4  operation code
- out_valid  output  1  result, branch and flags valid
- out_ready  input  1  consumer accepts the result
- result  output  W  operation result
- branch_result  output  1  BNZ outcome
- zero_flag  output  1  result == 0
- carry_flag  output  1  carry/borrow/overflow indication, per op

Behaviour:
- Opcodes:
  - 0 SLB: {read1[W-1:W/2], read0[W/2-1:0]}
  - 1 ADD
  - 2 SUB
  - 3 SHL: logical left shift of read1 by read0
  - 4 SHR: logical right shift of read1 by read0
  - 5 BNZ: branch_result = (read1 != 0); result = 0
  - 6 SLT: unsigned; result = 1 or 0
  - 7 XOR
  - 8 AND
  - 9 OR
  - 10 MUL: unsigned; result = low W bits of the product
  - 11 SRA: arithmetic right shift of read1 by read0
  - 12–15: NOP; result 0, branch 0, flags 0
- States:
  - IDLE: in_ready = 1
  - BUSY: iterating
  - DONE: out_valid = 1
- Accept occurs when in_valid && in_ready. On accept, operands and opcode are latched. Inputs are ignored in BUSY and DONE.
- Single-cycle ops (0–2, 5–9, 12–15): IDLE→DONE on accept. out_valid asserts the cycle after accept (latency 1).
- Shift ops (3, 4, 11):
  - Shift count = min(read0, W), latched at accept.
  - Count 0: IDLE→DONE, latency 1, result = read1.
  - Otherwise IDLE→BUSY. One bit is shifted per cycle. BUSY→DONE after the last bit, so latency = count + 1.
  - Amounts ≥ W saturate: SHL/SHR give 0; SRA gives all copies of read1[W-1].
- MUL:
  - Shift-add, one multiplier bit per cycle.
  - Always W cycles in BUSY; latency W + 1.
- DONE→IDLE when out_ready = 1. Until then out_valid, result and flags hold stable. No new accept occurs in the DONE→IDLE cycle; in_ready rises the following cycle. Maximum throughput is therefore one op per 2 cycles.
- carry_flag:
  - ADD: carry out of bit W-1
  - SUB: borrow (read1 < read0)
  - SHL: any 1 bit shifted out
  - MUL: high W bits of the product nonzero
  - all other ops: 0
- zero_flag = (result == 0) for every op, including BNZ and NOPs, where it is 1.
- All arithmetic is modulo 2^W. Outputs are registered; no combinational path from inputs to outputs except none. `in_ready` depends on state only.
- Reset, at any time including mid-BUSY or in DONE: state goes to IDLE and the operation in flight is discarded with no output.
  - Outputs after reset: in_ready = 1, out_valid = 0, result = 0, branch_result = 0, zero_flag = 0, carry_flag = 0, internal counter = 0.
- in_valid during reset is ignored.
- Outputs while not out_valid: hold the last value; they are only guaranteed when out_valid = 1.

Test Plan:
- W=8, ADD read1=0xF0, read0=0x20, out_ready=1 → out_valid the cycle after accept; result=0x10, carry=1, zero=0. in_ready back to 1 two cycles after accept.
- SUB 0x05−0x05, then SLT 0x03, 0x07 → first op: result 0, zero=1, carry=0. Second op: result 1.
- SHL read1=0x81, read0=3 → out_valid at accept+4; result=0x08, carry=1. SRA read1=0x80, read0=9 → latency 9 (count saturated to 8); result=0xFF.
- MUL 0x10×0x11 → out_valid at accept+9; result=0x10, carry=1. MUL 0x0F×0x0F → result 0xE1, carry=0.
- Backpressure: BNZ read1=0 with out_ready=0 for 5 cycles → out_valid and outputs stable (branch=0, zero=1); in_ready stays 0 while in_valid is held high with a new op. Raising out_ready completes the transfer, then the new op is accepted.
- Reset asserted on the 4th BUSY cycle of a MUL → next cycle IDLE, in_ready=1, out_valid=0, all outputs 0. No result is ever presented for the aborted MUL. SLB 0xAB, 0xCD after reset → result 0xAD.
